// File: rtl/rx_bit_timer.sv
// rx_bit_timer: after an accepted start, issues one shift strobe per bit period
// for a latched number of bits, then a one-cycle frame_done pulse.
module rx_bit_timer #(
   parameter int CNT_WIDTH = 4,
   parameter int BIT_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [CNT_WIDTH-1:0] bit_period,
   input  logic [BIT_WIDTH-1:0] frame_bits,
   output logic                 shift_strobe,
   output logic                 frame_done,
   output logic                 busy,
   output logic [BIT_WIDTH-1:0] bit_index
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
   localparam logic [BIT_WIDTH-1:0] BIT_ONE = 1;
   logic [1:0]           state;
   logic [CNT_WIDTH-1:0] cyc_cnt, period_q;
   logic [BIT_WIDTH-1:0] bit_cnt, bits_q;
   logic                 strobe;
   assign strobe       = state == RUN && cyc_cnt == period_q - CNT_ONE;
   assign shift_strobe = strobe;
   assign frame_done   = state == DONE;
   assign busy         = state == RUN || state == DONE;
   assign bit_index    = bit_cnt;
   // abort blocks a same-cycle start so an abort/start pair never launches a frame
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cyc_cnt  <= '0;
         bit_cnt  <= '0;
         period_q <= '0;
         bits_q   <= '0;
      end else if (state != IDLE && abort) begin
         state   <= IDLE;
         cyc_cnt <= '0;
         bit_cnt <= '0;
      end else if (state == IDLE) begin
         if (start && !abort) begin
            period_q <= bit_period == '0 ? CNT_ONE : bit_period;
            bits_q   <= frame_bits == '0 ? BIT_ONE : frame_bits;
            cyc_cnt  <= '0;
            bit_cnt  <= '0;
            state    <= RUN;
         end
      end else if (state == RUN) begin
         if (strobe) begin
            cyc_cnt <= '0;
            bit_cnt <= bit_cnt + BIT_ONE;
            if (bit_cnt == bits_q - BIT_ONE) state <= DONE;
         end else begin
            cyc_cnt <= cyc_cnt + CNT_ONE;
         end
      end else begin
         state <= IDLE;
      end
   end
endmodule
